// File: rtl/display_unpack_pkg.sv
// Shared constants and helpers for the ping-pong line unpacker.
package display_unpack_pkg;

    localparam int UNPACK_LAT = 3;
    localparam int BANK_W     = 1;

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } timing_t;

    // Exponent of a power-of-two pack ratio (1 -> 0, 4 -> 2, 16 -> 4).
    function automatic int log2_pow2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/display_line_unpack_pp_if.sv
// Packed-word write bus from the frame-buffer read side into the line banks.
interface display_line_unpack_pp_if #(
    parameter int PACK_BIT = 96
);
    logic                i_wvalid;
    logic                i_wready;
    logic [PACK_BIT-1:0] i_wdata;
    logic                i_wlast;

    modport master (output i_wvalid, output i_wdata, output i_wlast, input i_wready);
    modport slave  (input i_wvalid, input i_wdata, input i_wlast, output i_wready);
endinterface

// File: rtl/common_shift_reg.sv
// Fixed-depth delay line with asynchronous clear.
module common_shift_reg #(
    parameter int D_WIDTH = 1,
    parameter int TAPE    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] d,
    output logic [D_WIDTH-1:0] q
);
    logic [D_WIDTH-1:0] taps [TAPE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPE; i++) taps[i] <= '0;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < TAPE; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[TAPE-1];
endmodule

// File: rtl/common_simple_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
module common_simple_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/display_unpack_slot_mux.sv
// Picks one pixel out of a packed RAM word, honouring slot order; zero outside the line span.
module display_unpack_slot_mux
    import display_unpack_pkg::*;
#(
    parameter int PIXEL_BIT = 24,
    parameter int PACK_DIV  = 4,
    parameter int SLOT_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIXEL_BIT*PACK_DIV-1:0] rdata,
    input  logic [SLOT_W-1:0]             slot,
    input  logic                          msb_first,
    input  logic                          vld,
    output logic [PIXEL_BIT-1:0]          data
);
    logic [SLOT_W-1:0]    sel;
    logic [PIXEL_BIT-1:0] pix;

    always_comb begin
        sel = msb_first ? (SLOT_W'(PACK_DIV - 1) - slot) : slot;
        pix = rdata[int'(sel) * PIXEL_BIT +: PIXEL_BIT];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data <= '0;
        else     data <= vld ? pix : '0;
    end
endmodule

// File: rtl/display_line_unpack_pp.sv
// Ping-pong line buffer: packed words in on the write bus, one pixel per clock out
// under DE/HS/VS, with mirror, slot order and underflow/overflow pulses.
module display_line_unpack_pp
    import display_unpack_pkg::*;
#(
    parameter int PIXEL_BIT  = 24,
    parameter int PACK_DIV   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 11
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    display_line_unpack_pp_if.slave    wr,
    input  logic                       i_de,
    input  logic                       i_hs,
    input  logic                       i_vs,
    input  logic                       i_mirror,
    input  logic                       i_msb_first,
    output logic                       o_de,
    output logic                       o_hs,
    output logic                       o_vs,
    output logic [PIXEL_BIT-1:0]       o_data,
    output logic [X_WIDTH-1:0]         o_x,
    output logic [Y_WIDTH-1:0]         o_y,
    output logic                       o_underflow,
    output logic                       o_overflow
);
    localparam int PACK_BIT = PIXEL_BIT * PACK_DIV;
    localparam int SLOT_LOG = log2_pow2(PACK_DIV);
    localparam int SLOT_W   = (SLOT_LOG > 0) ? SLOT_LOG : 1;
    localparam int CNT_W    = ADDR_WIDTH + 1;
    localparam int N_W      = CNT_W + SLOT_LOG;
    localparam int RAM_AW   = ADDR_WIDTH + BANK_W;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**ADDR_WIDTH);

    // Bank bookkeeping
    logic             wbank, rbank;
    logic [CNT_W-1:0] wptr;
    logic [1:0]       full;
    logic [CNT_W-1:0] count [2];
    logic             accept, drop, ram_we;

    // Line playback state
    logic             de_prev, de_rise, de_fall;
    logic             play_q, mirror_q, msb_q;
    logic [N_W-1:0]   len_q, n_q;
    logic [Y_WIDTH-1:0] y_q;
    logic             play_c, mirror_c, msb_c, vld_c;
    logic [N_W-1:0]   len_c, n_c, m_c;
    logic [ADDR_WIDTH-1:0] word_c;
    logic [SLOT_W-1:0] slot_c;

    // Pipeline
    logic [RAM_AW-1:0]   raddr_p0;
    logic [SLOT_W-1:0]   slot_p0, slot_p1;
    logic                msb_p0, msb_p1;
    logic                vld_p0, vld_p1;
    logic [X_WIDTH-1:0]  x_p0, x_p1;
    logic [Y_WIDTH-1:0]  y_p0, y_p1;
    logic [PACK_BIT-1:0] rdata_p1;
    timing_t             tim_d, tim_q;

    assign wr.i_wready = ~full[wbank];
    assign accept      = wr.i_wvalid & wr.i_wready;
    assign drop        = accept & (wptr == DEPTH);
    assign ram_we      = accept & ~drop;

    assign de_rise = i_de & ~de_prev;
    assign de_fall = ~i_de & de_prev;

    // Line parameters are taken straight from the inputs on the rising-edge cycle
    // so pixel 0 is addressed in the same cycle DE rises.
    always_comb begin
        play_c   = play_q;
        mirror_c = mirror_q;
        msb_c    = msb_q;
        len_c    = len_q;
        n_c      = n_q;
        if (de_rise) begin
            play_c   = full[rbank];
            mirror_c = i_mirror;
            msb_c    = i_msb_first;
            len_c    = N_W'(count[rbank]) << SLOT_LOG;
            n_c      = '0;
        end
        vld_c  = i_de & play_c & (n_c < len_c);
        m_c    = mirror_c ? (len_c - N_W'(1) - n_c) : n_c;
        word_c = ADDR_WIDTH'(m_c >> SLOT_LOG);
        slot_c = SLOT_W'(m_c & N_W'(PACK_DIV - 1));
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wbank       <= 1'b0;
            rbank       <= 1'b0;
            wptr        <= '0;
            full        <= '0;
            count[0]    <= '0;
            count[1]    <= '0;
            de_prev     <= 1'b0;
            play_q      <= 1'b0;
            mirror_q    <= 1'b0;
            msb_q       <= 1'b0;
            len_q       <= '0;
            n_q         <= '0;
            y_q         <= '0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            de_prev     <= i_de;
            o_overflow  <= drop;
            o_underflow <= de_rise & ~full[rbank];
            if (accept) begin
                if (!drop) wptr <= wptr + 1'b1;
                if (wr.i_wlast) begin
                    count[wbank] <= drop ? wptr : wptr + 1'b1;
                    full[wbank]  <= 1'b1;
                    wptr         <= '0;
                    wbank        <= ~wbank;
                end
            end
            // Only a line that actually played consumes its bank.
            if (de_fall && play_q) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
            play_q   <= play_c;
            mirror_q <= mirror_c;
            msb_q    <= msb_c;
            len_q    <= len_c;
            if (i_de && (n_c != {N_W{1'b1}})) n_q <= n_c + 1'b1;
            if (i_vs)         y_q <= '0;
            else if (de_fall) y_q <= y_q + 1'b1;
        end
    end

    common_simple_dual_port_ram #(
        .DATA_WIDTH (PACK_BIT),
        .ADDR_WIDTH (RAM_AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr ({wbank, wptr[ADDR_WIDTH-1:0]}),
        .wdata (wr.i_wdata),
        .raddr (raddr_p0),
        .rdata (rdata_p1)
    );

    // t+1: RAM address and slot; t+2: RAM data lands alongside the delayed slot
    always_ff @(posedge i_clk) begin
        raddr_p0 <= {rbank, word_c};
        slot_p0  <= slot_c;
        msb_p0   <= msb_c;
        slot_p1  <= slot_p0;
        msb_p1   <= msb_p0;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            x_p0   <= '0;
            x_p1   <= '0;
            y_p0   <= '0;
            y_p1   <= '0;
            o_x    <= '0;
            o_y    <= '0;
        end else begin
            vld_p0 <= vld_c;
            vld_p1 <= vld_p0;
            x_p0   <= i_de ? X_WIDTH'(n_c) : '0;
            x_p1   <= x_p0;
            y_p0   <= y_q;
            y_p1   <= y_p0;
            o_x    <= x_p1;
            o_y    <= y_p1;
        end
    end

    // t+3: slot mux register
    display_unpack_slot_mux #(
        .PIXEL_BIT (PIXEL_BIT),
        .PACK_DIV  (PACK_DIV),
        .SLOT_W    (SLOT_W)
    ) u_slot_mux (
        .clk       (i_clk),
        .rst       (i_arst),
        .rdata     (rdata_p1),
        .slot      (slot_p1),
        .msb_first (msb_p1),
        .vld       (vld_p1),
        .data      (o_data)
    );

    assign tim_d = '{vs: i_vs, hs: i_hs, de: i_de};

    common_shift_reg #(
        .D_WIDTH (3),
        .TAPE    (UNPACK_LAT)
    ) u_timing_dly (
        .clk (i_clk),
        .rst (i_arst),
        .d   (tim_d),
        .q   (tim_q)
    );

    assign o_de = tim_q.de;
    assign o_hs = tim_q.hs;
    assign o_vs = tim_q.vs;
endmodule

// File: tb/tb_display_line_unpack_pp.sv
// Bench for display_line_unpack_pp: table of lines plus hand-written bank/overflow/reset sequences.
module tb_display_line_unpack_pp;
    localparam int PIXEL_BIT  = 24;
    localparam int PACK_DIV   = 4;
    localparam int ADDR_WIDTH = 10;
    localparam int X_WIDTH    = 12;
    localparam int Y_WIDTH    = 11;
    localparam int PACK_BIT   = PIXEL_BIT * PACK_DIV;

    logic clk = 1'b0;
    logic rst;
    logic i_de, i_hs, i_vs, i_mirror, i_msb_first;
    logic o_de, o_hs, o_vs, o_underflow, o_overflow;
    logic [PIXEL_BIT-1:0] o_data;
    logic [X_WIDTH-1:0]   o_x;
    logic [Y_WIDTH-1:0]   o_y;

    display_line_unpack_pp_if #(.PACK_BIT(PACK_BIT)) bus ();

    display_line_unpack_pp #(
        .PIXEL_BIT (PIXEL_BIT), .PACK_DIV (PACK_DIV), .ADDR_WIDTH (ADDR_WIDTH),
        .X_WIDTH (X_WIDTH), .Y_WIDTH (Y_WIDTH)
    ) dut (
        .i_clk (clk), .i_arst (rst), .wr (bus),
        .i_de (i_de), .i_hs (i_hs), .i_vs (i_vs),
        .i_mirror (i_mirror), .i_msb_first (i_msb_first),
        .o_de (o_de), .o_hs (o_hs), .o_vs (o_vs),
        .o_data (o_data), .o_x (o_x), .o_y (o_y),
        .o_underflow (o_underflow), .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int x; int data; int y; } pix_t;
    typedef struct { int nwords; int de_len; bit mirror; bit msb; int base; bit exp_uf; } line_t;

    pix_t sb[$];
    int n_cmp = 0, n_bad = 0;
    bit in_reset;
    int uf_cnt = 0, uf_cyc = -1, ov_cnt = 0, ov_cyc = -1, de_cnt = 0;
    bit first_pend;
    int first_cyc, rise_cyc, last_acc_cyc;
    int y_model;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    // Word w, slot s of a line starting at base holds pixel value base + w*PACK_DIV + s.
    function automatic int model_pix(int n, int nwords, bit mir, bit msb, int base);
        int len, m, w, s;
        len = nwords * PACK_DIV;
        if (n >= len) return 0;
        m = mir ? (len - 1 - n) : n;
        w = m / PACK_DIV;
        s = m % PACK_DIV;
        if (msb) s = PACK_DIV - 1 - s;
        return base + w * PACK_DIV + s;
    endfunction

    task automatic monitor();
        pix_t e;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (o_underflow) begin uf_cnt++; uf_cyc = cyc; end
                if (o_overflow)  begin ov_cnt++; ov_cyc = cyc; end
                if (o_de) begin
                    de_cnt++;
                    if (first_pend) begin first_cyc = cyc; first_pend = 0; end
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_underrun: o_de high with no pixel expected, o_x=%0d o_data=%0d", o_x, o_data);
                    end else begin
                        e = sb.pop_front();
                        check("pix_data", 32'(o_data), e.data);
                        check("pix_x", 32'(o_x), e.x);
                        check("pix_y", 32'(o_y), e.y);
                    end
                end
            end
        end
    endtask

    task automatic write_line(input int nwords, input int base);
        logic [PACK_BIT-1:0] wd;
        int tries;
        for (int w = 0; w < nwords; w++) begin
            @(posedge clk); #1;
            for (int s = 0; s < PACK_DIV; s++) wd[s*PIXEL_BIT +: PIXEL_BIT] = PIXEL_BIT'(base + w * PACK_DIV + s);
            bus.i_wvalid = 1'b1;
            bus.i_wdata  = wd;
            bus.i_wlast  = (w == nwords - 1);
            @(negedge clk);
            tries = 0;
            while (!bus.i_wready && tries < 64) begin
                @(posedge clk); #1;
                @(negedge clk);
                tries++;
            end
            if (!bus.i_wready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_stall: word %0d not accepted, i_wready=%0b expected 1", w, bus.i_wready);
                bus.i_wvalid = 1'b0;
                bus.i_wlast  = 1'b0;
                return;
            end
            last_acc_cyc = cyc;
        end
        @(posedge clk); #1;
        bus.i_wvalid = 1'b0;
        bus.i_wlast  = 1'b0;
    endtask

    task automatic play_line(input int nwords, input int de_len, input bit mir, input bit msb,
                             input int base, input bit exp_uf, input bit chk_release);
        int uf0, de0;
        uf0 = uf_cnt;
        de0 = de_cnt;
        @(posedge clk); #1; i_hs = 1'b1;
        @(posedge clk); #1; i_hs = 1'b0;
        @(posedge clk); #1;
        first_pend = 1;
        first_cyc  = -100;
        rise_cyc   = cyc;
        for (int n = 0; n < de_len; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            i_de = 1'b1;
            // Mode inputs are latched at the DE edge; flipping them afterwards must not matter.
            if (n == 0) begin i_mirror = mir; i_msb_first = msb; end
            if (n == 1) begin i_mirror = ~mir; i_msb_first = ~msb; end
            sb.push_back('{n % (1 << X_WIDTH), exp_uf ? 0 : model_pix(n, nwords, mir, msb, base), y_model});
        end
        @(posedge clk); #1;
        i_de = 1'b0; i_mirror = 1'b0; i_msb_first = 1'b0;
        y_model++;
        if (chk_release) begin
            @(negedge clk); check("wready_at_fall", 32'(bus.i_wready), 0);
            @(negedge clk); check("wready_after_fall", 32'(bus.i_wready), 1);
        end
        repeat (6) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        check("latency", first_cyc - rise_cyc, 3);
        check("de_len", de_cnt - de0, de_len);
        check("uf_count", uf_cnt - uf0, exp_uf ? 1 : 0);
        if (exp_uf) check("uf_time", uf_cyc - rise_cyc, 1);
    endtask

    line_t tbl[7];

    initial begin
        int ov0;
        tbl[0] = '{8, 32, 0, 0,   0, 0};
        tbl[1] = '{8, 32, 1, 0,   0, 0};
        tbl[2] = '{8, 32, 0, 1,   0, 0};
        tbl[3] = '{8, 40, 0, 0, 100, 0};
        tbl[4] = '{0, 16, 0, 0,   0, 1};
        tbl[5] = '{8, 32, 1, 1, 200, 0};
        tbl[6] = '{3, 12, 1, 0, 300, 0};

        rst = 1'b1; in_reset = 1;
        i_de = 0; i_hs = 0; i_vs = 0; i_mirror = 0; i_msb_first = 0;
        bus.i_wvalid = 0; bus.i_wdata = '0; bus.i_wlast = 0;
        y_model = 0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_de", 32'(o_de), 0);
        check("rst_o_data", 32'(o_data), 0);
        check("rst_o_x", 32'(o_x), 0);
        check("rst_o_y", 32'(o_y), 0);
        check("rst_underflow", 32'(o_underflow), 0);
        check("rst_overflow", 32'(o_overflow), 0);
        check("rst_wready", 32'(bus.i_wready), 1);
        rst = 1'b0; in_reset = 0;

        // HS/VS go through the same 3-cycle delay as DE.
        @(posedge clk); #1; i_vs = 1; i_hs = 1;
        @(posedge clk); #1; i_vs = 0; i_hs = 0;
        @(negedge clk); check("vs_dly1", 32'(o_vs), 0);
        @(negedge clk); check("vs_dly2", 32'(o_vs), 0);
        @(negedge clk); check("vs_dly3", 32'(o_vs), 1); check("hs_dly3", 32'(o_hs), 1);
        @(negedge clk); check("vs_dly4", 32'(o_vs), 0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].nwords > 0) write_line(tbl[i].nwords, tbl[i].base);
            play_line(tbl[i].nwords, tbl[i].de_len, tbl[i].mirror, tbl[i].msb,
                      tbl[i].base, tbl[i].exp_uf, 0);
        end

        // Both banks full blocks the writer until the first line is released.
        write_line(8, 800);
        write_line(8, 900);
        #1 check("wready_both_full", 32'(bus.i_wready), 0);
        play_line(8, 32, 0, 0, 800, 0, 1);
        play_line(8, 32, 0, 0, 900, 0, 0);

        // 1025 words into a 1024-word bank: last word dropped, count saturates.
        ov0 = ov_cnt;
        write_line(1025, 7);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_count", ov_cnt - ov0, 1);
        check("ovf_time", ov_cyc - last_acc_cyc, 1);
        play_line(1024, 4097, 0, 0, 7, 0, 0);

        // Reset in the middle of a playing line with both banks full.
        write_line(8, 500);
        write_line(8, 600);
        @(posedge clk); #1;
        first_pend = 0;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            i_de = 1'b1;
            sb.push_back('{n, model_pix(n, 8, 0, 0, 500), y_model});
        end
        @(posedge clk); #1;
        in_reset = 1; rst = 1'b1; i_de = 1'b0;
        #1;
        check("arst_o_de", 32'(o_de), 0);
        check("arst_o_data", 32'(o_data), 0);
        check("arst_o_x", 32'(o_x), 0);
        check("arst_o_y", 32'(o_y), 0);
        check("arst_wready", 32'(bus.i_wready), 1);
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; in_reset = 0; y_model = 0;
        write_line(8, 700);
        play_line(8, 32, 0, 0, 700, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "timeout");
    end
endmodule
